// File: rtl/coef_bank_if.sv
// coef_bank_if: groups the read, writeback and external-port signals of the coefficient bank.
// Latency: none; plain wires between the stage controller/datapath side and the bank.
// Backpressure: none; strobes are single-cycle and the bank never stalls them.
interface coef_bank_if #(
   parameter int DATA_W = 128,
   parameter int ADDR_W = 8
);
   logic              i_start;
   logic              i_stage_end;
   logic              i_rd_en;
   logic [ADDR_W-1:0] i_rd_addr1;
   logic [ADDR_W-1:0] i_rd_addr2;
   logic [DATA_W-1:0] o_rd_data1;
   logic [DATA_W-1:0] o_rd_data2;
   logic              o_rd_valid;
   logic              i_wb_valid;
   logic [ADDR_W-1:0] i_wb_addr1;
   logic [ADDR_W-1:0] i_wb_addr2;
   logic [DATA_W-1:0] i_wb_data1;
   logic [DATA_W-1:0] i_wb_data2;
   logic              i_ext_wr_en;
   logic              i_ext_rd_en;
   logic [ADDR_W-1:0] i_ext_addr;
   logic [DATA_W-1:0] i_ext_wdata;
   logic [DATA_W-1:0] o_ext_rdata;
   logic              o_ext_rvalid;
   logic              o_busy;
   logic              o_stage_done;
   logic              o_err;

   modport master (
      output i_start, i_stage_end, i_rd_en, i_rd_addr1, i_rd_addr2,
             i_wb_valid, i_wb_addr1, i_wb_addr2, i_wb_data1, i_wb_data2,
             i_ext_wr_en, i_ext_rd_en, i_ext_addr, i_ext_wdata,
      input  o_rd_data1, o_rd_data2, o_rd_valid, o_ext_rdata, o_ext_rvalid,
             o_busy, o_stage_done, o_err
   );

   modport slave (
      input  i_start, i_stage_end, i_rd_en, i_rd_addr1, i_rd_addr2,
             i_wb_valid, i_wb_addr1, i_wb_addr2, i_wb_data1, i_wb_data2,
             i_ext_wr_en, i_ext_rd_en, i_ext_addr, i_ext_wdata,
      output o_rd_data1, o_rd_data2, o_rd_valid, o_ext_rdata, o_ext_rvalid,
             o_busy, o_stage_done, o_err
   );
endinterface

// File: rtl/coef_bank.sv
// coef_bank: 2**ADDR_W x DATA_W coefficient scratchpad; paired NTT reads, in-place writeback, IDLE-only load/unload port.
// Latency: datapath and external reads return registered data 1 cycle after the accepted strobe; writes visible next cycle.
// Backpressure: none; illegal strobes are dropped and set sticky o_err. Option macro COEF_BANK_BYPASS_EN forwards writeback to RUN reads.
module coef_bank #(
   parameter int DATA_W = 128,
   parameter int ADDR_W = 8
) (
   input  logic       clk,
   input  logic       i_resetn,
   coef_bank_if.slave bus
);
   localparam int              DEPTH   = 1 << ADDR_W;
   localparam logic [ADDR_W:0] CNT_MAX = '1;

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W:0]   cnt;
   logic [ADDR_W:0]   cnt_nxt;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              rd_acc;
   logic              wb_acc;
   logic              ext_wr_acc;
   logic              ext_rd_acc;
   logic              cnt_err;
   logic              err_evt;
   logic              done_nxt;
   logic [DATA_W-1:0] rd_word1;
   logic [DATA_W-1:0] rd_word2;

   assign bus.o_busy = (state != IDLE);

   // Qualify each strobe against the current state.
   always_comb begin
      rd_acc     = (state == RUN) && bus.i_rd_en;
      wb_acc     = (state != IDLE) && bus.i_wb_valid;
      ext_wr_acc = (state == IDLE) && bus.i_ext_wr_en;
      ext_rd_acc = (state == IDLE) && bus.i_ext_rd_en;
   end

   // Outstanding reads: a read and a writeback in the same cycle cancel; saturate instead of wrapping.
   always_comb begin
      cnt_nxt = cnt;
      cnt_err = 1'b0;
      if (rd_acc && !wb_acc) begin
         if (cnt == CNT_MAX) cnt_err = 1'b1;
         else                cnt_nxt = cnt + 1'b1;
      end else if (wb_acc && !rd_acc) begin
         if (cnt == '0) cnt_err = 1'b1;
         else           cnt_nxt = cnt - 1'b1;
      end
   end

   // Stage sequencing; DRAIN leaves only once the registered count is seen at zero.
   always_comb begin
      state_nxt = state;
      done_nxt  = 1'b0;
      case (state)
         IDLE:    if (bus.i_start) state_nxt = RUN;
         RUN:     if (bus.i_stage_end) state_nxt = DRAIN;
         DRAIN:   if (cnt == '0) begin
                     state_nxt = IDLE;
                     done_nxt  = 1'b1;
                  end
         default: state_nxt = IDLE;
      endcase
   end

   // Any protocol violation in this cycle.
   always_comb begin
      err_evt = cnt_err;
      if (bus.i_start && (state != IDLE))                        err_evt = 1'b1;
      if (bus.i_rd_en && (state != RUN))                         err_evt = 1'b1;
      if (bus.i_wb_valid && (state == IDLE))                     err_evt = 1'b1;
      if (wb_acc && (bus.i_wb_addr1 == bus.i_wb_addr2))          err_evt = 1'b1;
      if ((bus.i_ext_wr_en || bus.i_ext_rd_en) && (state != IDLE)) err_evt = 1'b1;
   end

   // Read words; the forwarding option lets a same-cycle writeback win, port 2 over port 1.
   always_comb begin
      rd_word1 = mem[bus.i_rd_addr1];
      rd_word2 = mem[bus.i_rd_addr2];
`ifdef COEF_BANK_BYPASS_EN
      if (wb_acc) begin
         if (bus.i_rd_addr1 == bus.i_wb_addr2)      rd_word1 = bus.i_wb_data2;
         else if (bus.i_rd_addr1 == bus.i_wb_addr1) rd_word1 = bus.i_wb_data1;
         if (bus.i_rd_addr2 == bus.i_wb_addr2)      rd_word2 = bus.i_wb_data2;
         else if (bus.i_rd_addr2 == bus.i_wb_addr1) rd_word2 = bus.i_wb_data1;
      end
`endif
   end

   // State and outstanding-count registers.
   always_ff @(posedge clk) begin
      if (!i_resetn) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Registered outputs; read data holds until the next accepted read.
   always_ff @(posedge clk) begin
      if (!i_resetn) begin
         bus.o_rd_valid   <= 1'b0;
         bus.o_ext_rvalid <= 1'b0;
         bus.o_stage_done <= 1'b0;
         bus.o_err        <= 1'b0;
         bus.o_rd_data1   <= '0;
         bus.o_rd_data2   <= '0;
         bus.o_ext_rdata  <= '0;
      end else begin
         bus.o_rd_valid   <= rd_acc;
         bus.o_ext_rvalid <= ext_rd_acc;
         bus.o_stage_done <= done_nxt;
         if (err_evt) bus.o_err <= 1'b1;
         if (rd_acc) begin
            bus.o_rd_data1 <= rd_word1;
            bus.o_rd_data2 <= rd_word2;
         end
         if (ext_rd_acc) bus.o_ext_rdata <= mem[bus.i_ext_addr];
      end
   end

   // Storage is never cleared; port 2 is written last so it wins an address collision.
   always_ff @(posedge clk) begin
      if (i_resetn) begin
         if (wb_acc) begin
            mem[bus.i_wb_addr1] <= bus.i_wb_data1;
            mem[bus.i_wb_addr2] <= bus.i_wb_data2;
         end
         if (ext_wr_acc) mem[bus.i_ext_addr] <= bus.i_ext_wdata;
      end
   end
endmodule

// File: doc/coef_bank.md
# coef_bank

Coefficient scratchpad for the NTT butterfly datapath. It holds one polynomial as 256 words of 128 bits. It serves paired reads at the addresses produced by address generation and presents them as `i_data1`/`i_data2`/`i_valid` to the datapath. It writes the datapath results (`o_data1`/`o_data2` at `o_addr1`/`o_addr2` when `o_valid`) back in place. An external port loads and unloads the bank between transforms.

## Interface
- `DATA_W`, 128, coefficient word width
- `ADDR_W`, 8, address width; depth is 2**ADDR_W
- `clk`  in  1  clock
- `i_resetn`  in  1  synchronous, active-low reset; one clock; reset is synchronous and active-low
- `i_start`  in  1  pulse; begins a stage (IDLE only)
- `i_stage_end`  in  1  pulse; no further reads this stage
- `i_rd_en`  in  1  paired read request
- `i_rd_addr1`, `i_rd_addr2`  in  ADDR_W  read addresses
- `o_rd_data1`, `o_rd_data2`  out  DATA_W  to datapath `i_data1`/`i_data2`
- `o_rd_valid`  out  1  to datapath `i_valid`
- `i_wb_valid`  in  1  datapath result valid
- `i_wb_addr1`, `i_wb_addr2`  in  ADDR_W  writeback addresses
- `i_wb_data1`, `i_wb_data2`  in  DATA_W  writeback data
- `i_ext_wr_en`, `i_ext_rd_en`  in  1  external write/read strobes
- `i_ext_addr`  in  ADDR_W  external address
- `i_ext_wdata`  in  DATA_W  external write data
- `o_ext_rdata`  out  DATA_W  external read data
- `o_ext_rvalid`  out  1  external read data valid
- `o_busy`  out  1  state != IDLE
- `o_stage_done`  out  1  one-cycle pulse; stage fully written back
- `o_err`  out  1  sticky protocol error

## Operation
- **States:** IDLE, RUN, DRAIN.
  - IDLE → RUN on `i_start`.
  - RUN → DRAIN on `i_stage_end`.
  - DRAIN → IDLE when the outstanding count is 0; `o_stage_done` is pulsed on that transition.
  - `i_start` outside IDLE is ignored and sets `o_err`.
- **Reads:**
  - In RUN, `i_rd_en` reads both addresses into registered outputs.
  - `i_rd_en` outside RUN is ignored and sets `o_err`.
  - `i_rd_addr1 == i_rd_addr2` is legal; both outputs carry the same word.
- **Writeback:**
  - Accepted in RUN and DRAIN whenever `i_wb_valid` is high.
  - In IDLE, writeback is ignored and sets `o_err`.
  - If `i_wb_addr1 == i_wb_addr2`, `i_wb_data2` is written and `o_err` is set.
- **Outstanding counter:**
  - ADDR_W+1 bits.
  - +1 per accepted read, −1 per accepted writeback; a simultaneous read and writeback leaves it unchanged.
  - A decrement at 0 or an increment at maximum is suppressed (the counter holds its value) and sets `o_err`.
- **External port:**
  - Active only in IDLE; outside IDLE, an external access is ignored and sets `o_err`.
  - If `i_ext_wr_en` and `i_ext_rd_en` are both high, the write is performed and the read returns the old data.
- **Same-cycle read/write to the same address:** without the macro, the read returns the old contents.
- **Memory:** contents are never reset.

## Timing
- **Reset values:**
  - state IDLE, counter 0.
  - `o_rd_valid`, `o_ext_rvalid`, `o_stage_done`, `o_err`, `o_busy` are 0.
  - `o_rd_data*` and `o_ext_rdata` are 0.
- **Read latency:** 1 cycle. `i_rd_en` at cycle t gives `o_rd_valid` and data at t+1.
  - `o_rd_valid` is high for exactly one cycle per accepted request.
  - The data holds until the next accepted read.
- **External read latency:** 1 cycle, with the same rule as above.
- **Writes:** visible to a read issued the following cycle.
- **`o_stage_done`:** asserted the cycle after the counter is observed 0 in DRAIN.
  - If `i_stage_end` arrives with the counter already 0, `o_stage_done` fires 2 cycles after `i_stage_end`.
- **`o_busy`:** falls together with `o_stage_done`.
- **`i_stage_end` and `i_rd_en` in the same cycle:** the read is accepted, then the block goes to DRAIN.
- **`o_err`:** cleared only by reset.
- **Reset mid-RUN/DRAIN:** the block returns to IDLE next cycle, no `o_stage_done` pulse is produced, and memory holds whatever has been written so far.

## Configuration
- **`COEF_BANK_BYPASS_EN` defined:** a RUN read whose address matches a same-cycle accepted writeback returns the writeback data.
  - If the address matches both writeback ports, `i_wb_data2` is returned.
- **`COEF_BANK_BYPASS_EN` undefined:** the read returns the old contents, and there is no forwarding logic.

## Test plan
- **Load/unload:** in IDLE, write addr k with data {k, ~k} for k = 0..255, then read them back → each `o_ext_rdata` is correct 1 cycle after its strobe; `o_err` stays 0.
- **Stage:** `i_start`, then 128 paired reads (addr1 = 2i, addr2 = 2i+1), each written back with data+1 three cycles later, then `i_stage_end`.
  - Required: every `o_rd_valid` arrives 1 cycle after its `i_rd_en`.
  - Required: `o_stage_done` pulses 1 cycle after the last writeback drains the counter.
  - Required: a subsequent unload shows every word incremented.
- **Same-cycle hazard:** in RUN, read addr 5 while writing back addr 5 = 0xAA.
  - Without the macro, the read returns the old word; with the macro, it returns 0xAA.
  - The next read of addr 5 returns 0xAA in both builds.
- **Errors:** an external write in RUN, `i_start` in RUN, and a writeback with addr1 == addr2 = 9 (data2 = 0x33) must each set `o_err`.
  - The external write must leave memory unchanged.
  - Addr 9 must hold 0x33.
- **Reset:** assert `i_resetn` = 0 for 1 cycle in DRAIN with 3 outstanding.
  - Required: next cycle IDLE, counter 0, all outputs at reset values, no `o_stage_done`.
  - Required: previously loaded words remain readable.
